// File: rtl/spi2icb_pkg.sv
// spi2icb_pkg: shared state encodings, command code and default widths for the SPI-to-ICB bridge
package spi2icb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        ADDR = 2'd2,
        DATA = 2'd3
    } state_t;
    localparam logic ICB_CMD_RD = 1'b1;
    localparam int   AW_DEF     = 8;
    localparam int   DW_DEF     = 8;
endpackage

// File: rtl/spi2icb_sync.sv
// spi2icb_sync: 2-flop synchronizer plus a third flop for rise/fall pulse detection
module spi2icb_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [2:0] s;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) s <= '0;
        else        s <= {s[1:0], d};
    assign q    = s[1];
    assign rise = s[1] & ~s[2];
    assign fall = ~s[1] & s[2];
endmodule

// File: rtl/spi2icb.sv
// spi2icb: SPI mode-0 slave to ICB master bridge with auto-incrementing burst access
module spi2icb
    import spi2icb_pkg::*;
#(
    parameter int aw = AW_DEF,
    parameter int dw = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_csn,
    input  logic          spi_sck,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          spi_miso_oe,
    output logic          icb_wr,
    output logic [aw-1:0] icb_wadr,
    output logic [dw-1:0] icb_wdat,
    output logic          icb_rd,
    output logic [aw-1:0] icb_radr,
    input  logic [dw-1:0] icb_rdat
);
    localparam int cw = $clog2(aw > dw ? aw : dw);
    localparam logic [cw-1:0] alast = cw'(aw - 1);
    localparam logic [cw-1:0] dlast = cw'(dw - 1);
    state_t        state, nxt;
    logic          csn_q, csn_rise, csn_fall, sck_rise, sck_fall;
    logic [1:0]    mosi_s;
    logic          mosi_q, bit_ok, cmd, miso_r;
    logic [cw-1:0] cnt;
    logic [aw-1:0] adr;
    logic [dw-1:0] rx, tx;
    spi2icb_sync u_csn (.clk(clk), .rst_n(rst_n), .d(spi_csn), .q(csn_q), .rise(csn_rise), .fall(csn_fall));
    spi2icb_sync u_sck (.clk(clk), .rst_n(rst_n), .d(spi_sck), .q(), .rise(sck_rise), .fall(sck_fall));
    // mosi sees the same two-flop delay as the sck data path so it stays aligned with sck_rise
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) mosi_s <= '0;
        else        mosi_s <= {mosi_s[0], spi_mosi};
    assign mosi_q = mosi_s[1];
    // a chip-select rise in the same clk as a sampling edge wins and drops that bit
    assign bit_ok = sck_rise & ~csn_rise;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    always_comb
        nxt = state == IDLE ? (csn_fall ? CMD : IDLE) :
              csn_rise ? IDLE :
              (state == CMD && bit_ok) ? ADDR :
              (state == ADDR && bit_ok && cnt == alast) ? DATA : state;
    always_comb begin
        spi_miso_oe = state == DATA && cmd == ICB_CMD_RD && !csn_q;
        spi_miso    = spi_miso_oe & miso_r;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            adr      <= '0;
            rx       <= '0;
            tx       <= '0;
            cmd      <= 1'b0;
            miso_r   <= 1'b0;
            icb_wr   <= 1'b0;
            icb_rd   <= 1'b0;
            icb_wadr <= '0;
            icb_wdat <= '0;
            icb_radr <= '0;
        end else begin
            icb_wr <= 1'b0;
            icb_rd <= 1'b0;
            if (state == IDLE) begin
                cnt    <= '0;
                adr    <= '0;
                rx     <= '0;
                tx     <= '0;
                miso_r <= 1'b0;
            end
            if (state == CMD && bit_ok) begin
                cmd <= mosi_q;
                cnt <= '0;
            end
            if (state == ADDR && bit_ok) begin
                adr <= {adr[aw-2:0], mosi_q};
                cnt <= cnt == alast ? '0 : cnt + 1'b1;
                if (cnt == alast && cmd == ICB_CMD_RD) begin
                    icb_rd   <= 1'b1;
                    icb_radr <= {adr[aw-2:0], mosi_q};
                end
            end
            if (state == DATA) begin
                if (bit_ok) begin
                    rx  <= {rx[dw-2:0], mosi_q};
                    cnt <= cnt == dlast ? '0 : cnt + 1'b1;
                    if (cnt == dlast) begin
                        adr <= adr + 1'b1;
                        if (cmd == ICB_CMD_RD) begin
                            icb_rd   <= 1'b1;
                            icb_radr <= adr + 1'b1;
                        end else begin
                            icb_wr   <= 1'b1;
                            icb_wadr <= adr;
                            icb_wdat <= {rx[dw-2:0], mosi_q};
                        end
                    end
                end
                if (cmd == ICB_CMD_RD && sck_fall) begin
                    miso_r <= tx[dw-1];
                    tx     <= tx << 1;
                end
                if (icb_rd) tx <= icb_rdat;
            end
        end
    end
endmodule
